// File: rtl/sim_result_monitor_if.sv
// Data-memory store bus and pc of the RV32I core, as observed by the end-of-test monitor.
// The core (or a bench standing in for it) drives the master side; the monitor only listens.
interface sim_result_monitor_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] pc;

    modport master (output memwrite, output dataadr, output writedata, output pc);
    modport slave  (input  memwrite, input  dataadr, input  writedata, input  pc);
endinterface

// File: rtl/sim_result_monitor.sv
// End-of-test monitor: watches core stores and pc, latches a sticky PASS/FAIL/TIMEOUT verdict
// and keeps saturating store/cycle counters plus the last store seen while running.
module sim_result_monitor #(
    parameter logic [31:0] PASS_ADDR   = 32'd84,
    parameter logic [31:0] PASS_DATA   = 32'd7,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    sim_result_monitor_if.slave      bus,
    output logic [1:0]               state,
    output logic                     done,
    output logic [1:0]               fail_code,
    output logic [CNT_W-1:0]         store_cnt,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [31:0]              last_st_pc,
    output logic [31:0]              last_st_data
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } mon_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_SIG   = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;

    localparam int unsigned   STALL_W      = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_LIMIT - 2);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Illegal parameterisations stop elaboration rather than silently misbehaving.
    if (64'(TIMEOUT_CYC) > (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("sim_result_monitor: TIMEOUT_CYC exceeds 2**CNT_W");
    end
    if (TIMEOUT_CYC < 2 || STALL_LIMIT < 2) begin : g_bad_limits
        $error("sim_result_monitor: TIMEOUT_CYC and STALL_LIMIT must be >= 2");
    end

    mon_state_e          state_q, state_d;
    logic [1:0]          fail_code_q, fail_code_d;
    logic [CNT_W-1:0]    store_cnt_q, cycle_cnt_q;
    logic [31:0]         last_st_pc_q, last_st_data_q;
    logic [31:0]         pc_shadow_q;
    logic [STALL_W-1:0]  stall_cnt_q;

    logic in_run, sig_store, sig_ok, pc_same, stall_hit, timeout_hit;

    assign in_run      = (state_q == ST_RUN);
    assign sig_store   = bus.memwrite && (bus.dataadr == PASS_ADDR);
    assign sig_ok      = (bus.writedata == PASS_DATA);
    assign pc_same     = (bus.pc == pc_shadow_q);
    // This edge's increment would bring the repeat count to STALL_LIMIT-1.
    assign stall_hit   = pc_same && (stall_cnt_q == STALL_HIT);
    assign timeout_hit = (cycle_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            fail_code_q <= fail_code_d;
        end
    end

    // Verdict priority: signature store, then pc stall, then timeout. Verdicts are terminal.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code_q;
        if (in_run) begin
            if (sig_store) begin
                state_d     = sig_ok ? ST_PASS : ST_FAIL;
                fail_code_d = sig_ok ? FC_NONE : FC_SIG;
            end else if (stall_hit) begin
                state_d     = ST_FAIL;
                fail_code_d = FC_STALL;
            end else if (timeout_hit) begin
                state_d     = ST_TIMEOUT;
            end
        end
    end

    // The verdict cycle itself is still a RUN cycle, so it is counted and captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_cnt_q    <= '0;
            cycle_cnt_q    <= '0;
            last_st_pc_q   <= '0;
            last_st_data_q <= '0;
            pc_shadow_q    <= '0;
            stall_cnt_q    <= '0;
        end else if (in_run) begin
            cycle_cnt_q <= (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
            pc_shadow_q <= bus.pc;
            stall_cnt_q <= pc_same ? stall_cnt_q + 1'b1 : '0;
            if (bus.memwrite) begin
                store_cnt_q    <= (store_cnt_q == CNT_MAX) ? store_cnt_q : store_cnt_q + 1'b1;
                last_st_pc_q   <= bus.pc;
                last_st_data_q <= bus.writedata;
            end
        end
    end

    assign state        = state_q;
    assign done         = !in_run;
    assign fail_code    = fail_code_q;
    assign store_cnt    = store_cnt_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign last_st_pc   = last_st_pc_q;
    assign last_st_data = last_st_data_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Bench for sim_result_monitor: three parameterisations share one stimulus bus and are compared
// every cycle against a behavioural model, plus directed boundary scenarios.
module tb_sim_result_monitor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sim_result_monitor_if bus();

    // dut 0: defaults, dut 1: TIMEOUT_CYC=32, dut 2: CNT_W=4 / TIMEOUT_CYC=16
    logic [1:0]  s0, s1, s2, fc0, fc1, fc2;
    logic        d0, d1, d2;
    logic [15:0] st0, st1, cy0, cy1;
    logic [3:0]  st2, cy2;
    logic [31:0] lp0, lp1, lp2, ld0, ld1, ld2;

    sim_result_monitor dut0 (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .state(s0), .done(d0), .fail_code(fc0), .store_cnt(st0), .cycle_cnt(cy0),
        .last_st_pc(lp0), .last_st_data(ld0));

    sim_result_monitor #(.TIMEOUT_CYC(32)) dut1 (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .state(s1), .done(d1), .fail_code(fc1), .store_cnt(st1), .cycle_cnt(cy1),
        .last_st_pc(lp1), .last_st_data(ld1));

    sim_result_monitor #(.TIMEOUT_CYC(16), .CNT_W(4)) dut2 (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .state(s2), .done(d2), .fail_code(fc2), .store_cnt(st2), .cycle_cnt(cy2),
        .last_st_pc(lp2), .last_st_data(ld2));

    // ---------------- reference model ----------------
    localparam int PASS_ADDR = 84;
    localparam int PASS_DATA = 7;
    localparam int STALL_LIMIT = 16;
    int p_timeout[3] = '{1024, 32, 16};
    int p_max[3]     = '{65535, 65535, 15};

    int          m_state[3], m_fc[3], m_st[3], m_cy[3], m_repeats[3];
    logic [31:0] m_lpc[3], m_ldata[3], m_prev_pc[3];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cur_pc;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = 0; m_fc[k] = 0; m_st[k] = 0; m_cy[k] = 0; m_repeats[k] = 0;
            m_lpc[k] = '0; m_ldata[k] = '0; m_prev_pc[k] = '0;
        end
    endtask

    // One RUN cycle seen from the rules: count it, note repeats of pc, then decide the verdict.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (m_state[k] == 0) begin
                bit sig, stalled, timed_out;
                sig       = bus.memwrite && (bus.dataadr == PASS_ADDR);
                m_repeats[k] = (bus.pc == m_prev_pc[k]) ? m_repeats[k] + 1 : 0;
                stalled   = (m_repeats[k] == STALL_LIMIT - 1);
                m_prev_pc[k] = bus.pc;
                timed_out = (m_cy[k] + 1 == p_timeout[k]);
                m_cy[k]   = (m_cy[k] + 1 > p_max[k]) ? p_max[k] : m_cy[k] + 1;
                if (bus.memwrite) begin
                    m_st[k]    = (m_st[k] + 1 > p_max[k]) ? p_max[k] : m_st[k] + 1;
                    m_lpc[k]   = bus.pc;
                    m_ldata[k] = bus.writedata;
                end
                if (sig) begin
                    m_state[k] = (bus.writedata == PASS_DATA) ? 1 : 2;
                    m_fc[k]    = (bus.writedata == PASS_DATA) ? 0 : 1;
                end else if (stalled) begin
                    m_state[k] = 2;
                    m_fc[k]    = 2;
                end else if (timed_out) begin
                    m_state[k] = 3;
                end
            end
        end
    endtask

    // ---------------- scoreboard / checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] s, input logic d, input logic [1:0] fc,
                             input logic [15:0] st, input logic [15:0] cy,
                             input logic [31:0] lp, input logic [31:0] ld);
        check_eq($sformatf("d%0d_state", k), 64'(s), 64'(m_state[k]));
        check_eq($sformatf("d%0d_done", k), 64'(d), 64'(m_state[k] != 0));
        check_eq($sformatf("d%0d_fail_code", k), 64'(fc), 64'(m_fc[k]));
        check_eq($sformatf("d%0d_store_cnt", k), 64'(st), 64'(m_st[k]));
        check_eq($sformatf("d%0d_cycle_cnt", k), 64'(cy), 64'(m_cy[k]));
        check_eq($sformatf("d%0d_last_st_pc", k), 64'(lp), 64'(m_lpc[k]));
        check_eq($sformatf("d%0d_last_st_data", k), 64'(ld), 64'(m_ldata[k]));
    endtask

    task automatic check_all();
        check_dut(0, s0, d0, fc0, st0, cy0, lp0, ld0);
        check_dut(1, s1, d1, fc1, st1, cy1, lp1, ld1);
        check_dut(2, s2, d2, fc2, {12'd0, st2}, {12'd0, cy2}, lp2, ld2);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
        bus.memwrite  = mw;
        bus.dataadr   = adr;
        bus.writedata = wd;
        bus.pc        = cur_pc;
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cur_pc += 4;
            drive(1'b0, 32'd0, 32'd0);
            step();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        model_reset();
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cur_pc = 32'h100;
        drive(1'b0, 32'd0, 32'd0);
        model_reset();

        // 1: non-signature store, then pass store
        do_reset();
        run_idle(4);
        cur_pc += 4; drive(1'b1, 32'd80, 32'd3); step();
        check_eq("t1_state_before", 64'(s0), 64'd0);
        cur_pc += 4; drive(1'b1, 32'd84, 32'd7); step();
        check_eq("t1_state", 64'(s0), 64'd1);
        check_eq("t1_done", 64'(d0), 64'd1);
        check_eq("t1_store_cnt", 64'(st0), 64'd2);
        check_eq("t1_last_data", 64'(ld0), 64'd7);
        run_idle(3);
        check_eq("t1_sticky_cycles", 64'(cy0), 64'd6);

        // 2: bad signature, later good signature does not override
        do_reset();
        cur_pc += 4; drive(1'b1, 32'd84, 32'd5); step();
        check_eq("t2_state", 64'(s0), 64'd2);
        check_eq("t2_fail_code", 64'(fc0), 64'd1);
        cur_pc += 4; drive(1'b1, 32'd84, 32'd7); step();
        check_eq("t2_sticky_state", 64'(s0), 64'd2);
        check_eq("t2_sticky_data", 64'(ld0), 64'd5);

        // 3: timeout on dut1 after its 32nd RUN cycle
        do_reset();
        run_idle(31);
        check_eq("t3_run_at_31", 64'(s1), 64'd0);
        run_idle(1);
        check_eq("t3_timeout", 64'(s1), 64'd3);
        check_eq("t3_cycle_cnt", 64'(cy1), 64'd32);
        run_idle(5);
        check_eq("t3_cycle_frozen", 64'(cy1), 64'd32);
        check_eq("t3_dut0_running", 64'(s0), 64'd0);

        // 4a: pc held 16 cycles -> stall fail
        do_reset();
        cur_pc = 32'h40;
        for (int i = 0; i < 15; i++) begin drive(1'b0, 32'd0, 32'd0); step(); end
        check_eq("t4_run_at_15", 64'(s0), 64'd0);
        drive(1'b0, 32'd0, 32'd0); step();
        check_eq("t4_stall_state", 64'(s0), 64'd2);
        check_eq("t4_stall_code", 64'(fc0), 64'd2);

        // 4b: pass store on the stall-limit cycle wins
        do_reset();
        cur_pc = 32'h40;
        for (int i = 0; i < 15; i++) begin drive(1'b0, 32'd0, 32'd0); step(); end
        drive(1'b1, 32'd84, 32'd7); step();
        check_eq("t4_pass_wins", 64'(s0), 64'd1);
        check_eq("t4_pass_code", 64'(fc0), 64'd0);
        cur_pc = 32'h200;

        // 5: asynchronous reset mid-cycle after three stores
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cur_pc += 4; drive(1'b1, 32'd16 + 32'(i) * 4, 32'hA0 + 32'(i)); step();
        end
        check_eq("t5_stores", 64'(st0), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_state", 64'(s0), 64'd0);
        check_eq("t5_async_store_cnt", 64'(st0), 64'd0);
        check_eq("t5_async_cycle_cnt", 64'(cy0), 64'd0);
        check_eq("t5_async_last_pc", 64'(lp0), 64'd0);
        check_eq("t5_async_last_data", 64'(ld0), 64'd0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        run_idle(1);
        check_eq("t5_restart_cycle", 64'(cy0), 64'd1);

        // 6: saturating store count on the 4-bit instance
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cur_pc += 4; drive(1'b1, 32'd0, 32'(i)); step();
            if (i == 14) check_eq("t6_cnt_at_15", 64'(st2), 64'd15);
        end
        check_eq("t6_saturated", 64'(st2), 64'd15);
        check_eq("t6_wide_cnt", 64'(st0), 64'd20);
        check_eq("t6_wide_state", 64'(s0), 64'd0);

        // randomized episodes against the model
        for (int e = 0; e < 12; e++) begin
            int hold, len;
            do_reset();
            hold = 0;
            len = $urandom_range(20, 90);
            for (int c = 0; c < len; c++) begin
                logic        mw;
                logic [31:0] adr, wd;
                int          r;
                if (hold > 0) hold--;
                else if ($urandom_range(0, 19) == 0) hold = $urandom_range(8, 20);
                else cur_pc += 4;
                mw = ($urandom_range(0, 2) == 0);
                r  = $urandom_range(0, 9);
                adr = (r == 0) ? 32'd84 : (r == 1) ? 32'd80 : (r == 2) ? 32'd88
                                        : 32'($urandom_range(0, 63)) * 4;
                wd = (adr == 32'd84) ? (($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15)))
                                     : $urandom;
                drive(mw, adr, wd);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
